// File: rtl/beta_mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store unit share one
// single-outstanding memory port. LSU has priority, but a fetch that keeps
// losing is forced through after StarveLimit consecutive LSU wins.
module beta_mem_arbiter #(
  parameter int DataWidth   = 32,
  parameter int StarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 arb_if_req_i,
  input  logic [DataWidth-1:0] arb_if_addr_i,
  output logic                 arb_if_gnt_o,
  output logic                 arb_if_rvalid_o,
  input  logic                 arb_lsu_req_i,
  input  logic                 arb_lsu_we_i,
  input  logic [3:0]           arb_lsu_be_i,
  input  logic [DataWidth-1:0] arb_lsu_addr_i,
  input  logic [DataWidth-1:0] arb_lsu_wdata_i,
  output logic                 arb_lsu_gnt_o,
  output logic                 arb_lsu_rvalid_o,
  output logic [DataWidth-1:0] arb_rdata_o,
  output logic                 arb_mem_req_o,
  output logic                 arb_mem_we_o,
  output logic [3:0]           arb_mem_be_o,
  output logic [DataWidth-1:0] arb_mem_addr_o,
  output logic [DataWidth-1:0] arb_mem_wdata_o,
  input  logic                 arb_mem_gnt_i,
  input  logic                 arb_mem_rvalid_i,
  input  logic [DataWidth-1:0] arb_mem_rdata_i,
  output logic                 arb_busy_o,
  output logic                 arb_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] StarveMax = 3'(StarveLimit);

  state_t     state_reg, state_next;
  logic       owner_reg, owner_next;    // 1 = LSU owns the port, 0 = fetch
  logic [2:0] streak_reg, streak_next;  // consecutive LSU wins while fetch waited
  logic       any_req;
  logic       lsu_wins;
  logic       take;

  // Pick the next winner from the currently pending requests
  always_comb begin
    any_req  = arb_if_req_i | arb_lsu_req_i;
    lsu_wins = arb_lsu_req_i && !(arb_if_req_i && (streak_reg == StarveMax));
  end

  // Next state, owner latch and starvation streak update
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    streak_next = streak_reg;
    take        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          take = 1'b1;
        end
      end
      ADDR: begin
        if (arb_mem_gnt_i) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (arb_mem_rvalid_i) begin
          if (any_req) begin
            take = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // A new owner is only ever latched here, so it stays frozen through ADDR/RESP
    if (take) begin
      state_next = ADDR;
      owner_next = lsu_wins;
      if (lsu_wins && arb_if_req_i) begin
        streak_next = (streak_reg >= StarveMax) ? StarveMax : streak_reg + 3'd1;
      end else begin
        streak_next = 3'd0;
      end
    end
  end

  // State, owner and streak registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      streak_reg <= 3'd0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      streak_reg <= streak_next;
    end
  end

  // Memory-side drive, per-port handshakes and error flag from the current state
  always_comb begin
    arb_mem_req_o    = 1'b0;
    arb_mem_we_o     = 1'b0;
    arb_mem_be_o     = 4'h0;
    arb_mem_addr_o   = '0;
    arb_mem_wdata_o  = '0;
    arb_if_gnt_o     = 1'b0;
    arb_lsu_gnt_o    = 1'b0;
    arb_if_rvalid_o  = 1'b0;
    arb_lsu_rvalid_o = 1'b0;
    arb_rdata_o      = '0;
    arb_err_o        = 1'b0;
    arb_busy_o       = (state_reg != IDLE);
    case (state_reg)
      ADDR: begin
        arb_mem_req_o = 1'b1;
        if (owner_reg) begin
          arb_mem_we_o    = arb_lsu_we_i;
          arb_mem_be_o    = arb_lsu_be_i;
          arb_mem_addr_o  = arb_lsu_addr_i;
          arb_mem_wdata_o = arb_lsu_wdata_i;
        end else begin
          arb_mem_be_o    = 4'hF;
          arb_mem_addr_o  = arb_if_addr_i;
        end
        arb_if_gnt_o  = arb_mem_gnt_i && !owner_reg;
        arb_lsu_gnt_o = arb_mem_gnt_i && owner_reg;
        // Nothing can be outstanding before the grant, so any response is stray
        arb_err_o     = arb_mem_rvalid_i;
      end
      RESP: begin
        if (arb_mem_rvalid_i) begin
          arb_if_rvalid_o  = !owner_reg;
          arb_lsu_rvalid_o = owner_reg;
          arb_rdata_o      = arb_mem_rdata_i;
        end
      end
      default: begin
        arb_err_o = arb_mem_rvalid_i;
      end
    endcase
  end

endmodule
